// File: rtl/display_scanner.sv
// Scans one of three 4-digit 7-segment pages onto a shared common-anode display with a blanking gap per slot.
// Optional: `define DISP_AUTO_ROTATE_EN to auto-advance the page every ROTATE_FRAMES frames.
module display_scanner #(
  parameter int SCAN_DIV      = 50000,
  parameter int BLANK_CYC     = 8,
  parameter int ROTATE_FRAMES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digit_price,
  input  logic [31:0] digit_tm,
  input  logic [31:0] digit_dist,
  input  logic        page_next,
  output logic [1:0]  page_sel,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);

  if (SCAN_DIV <= BLANK_CYC || BLANK_CYC < 1 || ROTATE_FRAMES < 1) begin : g_bad_param
    $error("display_scanner: invalid SCAN_DIV/BLANK_CYC/ROTATE_FRAMES");
  end

  typedef enum logic {BLANK, DRIVE} phase_t;

  phase_t      phase, phase_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]  idx, idx_nx;
  logic [1:0]  page_nx;
  logic        pending, pending_nx;
  logic [3:0]  an_nx;
  logic [6:0]  seg_nx;
  logic        dp_nx;
  logic [31:0] word;
  logic [7:0]  byte_sel;
  logic        boundary;
  logic        advance;

`ifdef DISP_AUTO_ROTATE_EN
  localparam int RW = $clog2(ROTATE_FRAMES + 1);
  logic [RW-1:0] rot, rot_nx;
`endif

  always_comb begin
    case (page_sel)
      2'd0:    word = digit_price;
      2'd1:    word = digit_tm;
      2'd2:    word = digit_dist;
      default: word = 32'h0;
    endcase
    byte_sel = word[{idx, 3'b000} +: 8];
  end

  always_comb begin
    phase_nx   = phase;
    cnt_nx     = cnt + 1'b1;
    idx_nx     = idx;
    page_nx    = page_sel;
    pending_nx = pending | page_next;
    an_nx      = an;
    seg_nx     = seg;
    dp_nx      = dp;
    boundary   = 1'b0;
    advance    = 1'b0;
`ifdef DISP_AUTO_ROTATE_EN
    rot_nx     = rot;
`endif

    case (phase)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          phase_nx = DRIVE;
          // Loading seg/dp only here is what snapshots the digit for the whole slot.
          if (page_sel != 2'd3) begin
            an_nx  = ~(4'b0001 << idx);
            seg_nx = byte_sel[7:1];
            dp_nx  = byte_sel[0];
          end
        end
      end
      DRIVE: begin
        if (cnt == SLOT_LAST) begin
          phase_nx = BLANK;
          cnt_nx   = '0;
          idx_nx   = idx + 2'd1;
          an_nx    = 4'hF;
          seg_nx   = 7'h7F;
          dp_nx    = 1'b1;
          boundary = (idx == 2'd3);
        end
      end
      default: begin
        phase_nx = BLANK;
        cnt_nx   = '0;
      end
    endcase

    if (boundary) begin
      advance = pending | page_next;
`ifdef DISP_AUTO_ROTATE_EN
      rot_nx = rot + 1'b1;
      if (advance || rot_nx == RW'(ROTATE_FRAMES)) begin
        advance = 1'b1;
        rot_nx  = '0;
      end
`endif
      pending_nx = 1'b0;
      if (page_sel == 2'd3)
        page_nx = 2'd0;
      else if (advance)
        page_nx = (page_sel == 2'd2) ? 2'd0 : page_sel + 2'd1;
    end

    if (page_sel == 2'd3) begin
      an_nx  = 4'hF;
      seg_nx = 7'h7F;
      dp_nx  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= BLANK;
      cnt      <= '0;
      idx      <= 2'd0;
      page_sel <= 2'd0;
      pending  <= 1'b0;
      an       <= 4'hF;
      seg      <= 7'h7F;
      dp       <= 1'b1;
    end else begin
      phase    <= phase_nx;
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      page_sel <= page_nx;
      pending  <= pending_nx;
      an       <= an_nx;
      seg      <= seg_nx;
      dp       <= dp_nx;
    end
  end

`ifdef DISP_AUTO_ROTATE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rot <= '0;
    else     rot <= rot_nx;
  end
`endif

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: per-digit expectations queued per frame, checked every cycle.
module tb_display_scanner;
  localparam int SD = 10;
  localparam int BC = 2;
  localparam int RF = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] digit_price, digit_tm, digit_dist;
  logic        page_next = 1'b0;
  logic [1:0]  page_sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  display_scanner #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ROTATE_FRAMES(RF)) dut (
    .clk(clk), .rst(rst),
    .digit_price(digit_price), .digit_tm(digit_tm), .digit_dist(digit_dist),
    .page_next(page_next),
    .page_sel(page_sel), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] pg;
  } exp_t;

  exp_t       q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [1:0] pg_m;
  int         rot_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [1:0] p);
    case (p)
      2'd0:    return digit_price;
      2'd1:    return digit_tm;
      2'd2:    return digit_dist;
      default: return 32'h0;
    endcase
  endfunction

  task automatic push_frame();
    logic [31:0] w;
    exp_t e;
    w = word_of(pg_m);
    for (int i = 0; i < 4; i++) begin
      e.an  = ~(4'b0001 << i);
      e.seg = w[8*i+1 +: 7];
      e.dp  = w[8*i];
      e.pg  = pg_m;
      q.push_back(e);
    end
  endtask

  // Starts at a negedge where the DUT is at the first blank cycle of digit 0.
  task automatic run_frame(input int npos, input logic [39:0] pn, input int chg_pos, input logic [7:0] chg_val);
    exp_t e;
    e = '0;
    for (int p = 0; p < npos; p++) begin
      int c;
      c = p % SD;
      page_next = pn[p];
      if (p == chg_pos) digit_price[7:0] = chg_val;
      if (c == 0) begin
        vectors++;
        assert (q.size() != 0) else begin
          miscompares++;
          $error("FAIL sb_empty p%0d: observed size 0 expected >0", p);
        end
        if (q.size() != 0) e = q.pop_front();
      end
      if (c < BC) begin
        chk($sformatf("an_blank p%0d", p), an, 4'hF);
        chk($sformatf("seg_blank p%0d", p), seg, 7'h7F);
        chk($sformatf("dp_blank p%0d", p), dp, 1'b1);
      end else begin
        chk($sformatf("an p%0d", p), an, e.an);
        chk($sformatf("seg p%0d", p), seg, e.seg);
        chk($sformatf("dp p%0d", p), dp, e.dp);
      end
      chk($sformatf("page_sel p%0d", p), page_sel, e.pg);
      @(posedge clk);
      @(negedge clk);
    end
    page_next = 1'b0;
  endtask

  task automatic model_end(input logic man);
`ifdef DISP_AUTO_ROTATE_EN
    rot_m++;
    if (man || rot_m == RF) begin
      pg_m  = (pg_m == 2'd2) ? 2'd0 : pg_m + 2'd1;
      rot_m = 0;
    end
`else
    if (man) pg_m = (pg_m == 2'd2) ? 2'd0 : pg_m + 2'd1;
`endif
  endtask

  task automatic frame(input logic [39:0] pn, input int chg_pos, input logic [7:0] chg_val);
    push_frame();
    run_frame(40, pn, chg_pos, chg_val);
    model_end(|pn);
  endtask

  initial begin
    digit_price = 32'hFF9E0381;
    digit_tm    = 32'h81808181;
    digit_dist  = 32'h12345678;
    repeat (2) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_page", page_sel, 2'd0);
    rst = 1'b0;
    pg_m = 2'd0;
    rot_m = 0;

    // First frame uses literal per-digit values for the price word.
    q.push_back({4'b1110, 7'h40, 1'b1, 2'd0});
    q.push_back({4'b1101, 7'h01, 1'b1, 2'd0});
    q.push_back({4'b1011, 7'h4F, 1'b0, 2'd0});
    q.push_back({4'b0111, 7'h7F, 1'b1, 2'd0});
    run_frame(40, 40'd0, -1, 8'h00);
    model_end(1'b0);
    frame(40'd0, -1, 8'h00);
    frame(40'd0, 6, 8'h9F);
    frame(40'd0, -1, 8'h00);

    frame(40'd1 << 15, -1, 8'h00);
    frame((40'd1 << 3) | (40'd1 << 17) | (40'd1 << 30), -1, 8'h00);
    frame(40'd1 << 39, -1, 8'h00);
    frame(40'd0, -1, 8'h00);
    frame(40'd1 << 20, -1, 8'h00);

    // Reset asserted mid-DRIVE must blank everything without a clock edge.
    push_frame();
    run_frame(25, 40'd0, -1, 8'h00);
    rst = 1'b1;
    #1;
    chk("mid_rst_an", an, 4'hF);
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_dp", dp, 1'b1);
    chk("mid_rst_page", page_sel, 2'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pg_m = 2'd0;
    rot_m = 0;

`ifdef DISP_AUTO_ROTATE_EN
    repeat (4) frame(40'd0, -1, 8'h00);
    frame(40'd1 << 10, -1, 8'h00);
    repeat (4) frame(40'd0, -1, 8'h00);
`else
    repeat (25) frame(40'd0, -1, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
